hex_scroll_ctrl: RTL
====================

// Module: hex_scroll_ctrl
// PURPOSE
//  Sequencer for the 4-digit seven-segment datapath: scrolls a packed-BCD message of NDIG digits across HEX3..HEX0.
//  Prescaler-driven step timing. KEY buttons give run/pause, direction reverse and single-step. Status goes to LEDR.
//  Top-level board block; drives the decoder instances that feed HEX0-HEX3.
// PARAMETERS
//  NDIG      8             message length in digits, legal 4..8
//  MSG       32'hFFFF6145  packed message, digit i = MSG[4*i+:4]; nibble >9 renders blank
//  TICK_DIV  12_500_000    clock cycles per base tick (250 ms at 50 MHz), >=2
//  DEB_CYC   1_000_000     debounce stable-time in cycles (KEY_DEBOUNCE_EN only)
// PORTS
//  CLOCK_50  in   1    system clock, all logic on rising edge
//  RST       in   1    synchronous, active-high reset
//  KEY       in   2    push buttons, active-low (0 = pressed); asynchronous to CLOCK_50
//  SW        in   2    speed select: one step every SW+1 base ticks
//  HEX0..3   out  7    each is 7 bits, active-low segments, registered; HEX0 rightmost
//  LEDR      out  5    [0] running, [1] dir, [4:2] current pointer
// BEHAVIOUR
//  - Input path: KEY goes through a 2-flop synchronizer, then an optional debouncer.
//    A press is a 1->0 transition of the resulting level, detected as a 1-cycle pulse.
//  - FSM states: RUN, PAUSE.
//    - Reset -> RUN.
//    - KEY0 press toggles RUN<->PAUSE.
//    - KEY1 press: in RUN it toggles dir; in PAUSE it performs one immediate step in the current dir.
//    - KEY0 and KEY1 pressed in the same cycle: KEY0 wins, KEY1 press discarded.
//  - Prescaler: tick_cnt counts 0..TICK_DIV-1 in RUN only; tick pulse fires on wrap.
//    step_cnt counts ticks; a step occurs when tick fires with step_cnt >= SW, then step_cnt<=0.
//    Lowering SW mid-count therefore steps at the next tick.
//    PAUSE->RUN clears tick_cnt and step_cnt.
//    A tick coinciding with a pause press is dropped (no step).
//  - Step: dir=0 gives ptr<=(ptr+1) mod NDIG; dir=1 gives ptr<=(ptr==0 ? NDIG-1 : ptr-1).
//  - Display mapping: HEXk shows digit (ptr+k) mod NDIG, k=0..3.
//    HEX registers update 1 cycle after ptr changes, so latency from step to segments = 1 cycle.
//  - Reset values:
//    - Internal: ptr=0, dir=0, state RUN, all counters 0.
//    - Outputs: HEX0..3=7'h7F (blank) while RST asserted; first cycle after reset they show ptr=0 decode.
//    - LEDR=5'b00001 on the first cycle after reset.
//  - RST mid-scroll: takes effect next edge regardless of key/tick activity; pending presses are lost.
//  - Sync/debounce flops reset to 1 (released), so a key held through reset yields no press.
// CONFIGURATION
//  - KEY_DEBOUNCE_EN defined: each synchronized key must hold a new level for DEB_CYC consecutive cycles before the debounced level changes.
//    This adds DEB_CYC cycles of press latency.
//  - KEY_DEBOUNCE_EN undefined: the synchronized level is used directly; press latency is 3 cycles from the KEY edge (2 sync + 1 edge-detect).
// STRUCTURE
//  - Package hex_ui_pkg:
//    - SEG_BLANK=7'h7F
//    - seg constants for 0-9
//    - state enum {RUN, PAUSE}
//    - ptr width function clog2(NDIG)
//  - Sub-module bcd_to_seg: combinational 4-bit to 7-seg active-low, nibble >9 gives SEG_BLANK.
//    Four instances; the controller registers their outputs.
// TESTING (bench uses TICK_DIV=4, DEB_CYC=3, NDIG=8, MSG=32'hFFFF6145)
//  1 Reset 3 cycles, release -> next cycle HEX0..3 = seg(5),seg(4),seg(1),seg(6); LEDR=5'b00001.
//  2 SW=0, run 4 ticks (16 cycles) -> ptr 0->4, then HEX0..3 all blank; step 8 -> wrap to ptr 0, HEX restored.
//  3 SW=3 -> exactly one step per 16 cycles; change SW to 0 mid-count -> step at next tick.
//  4 KEY0 press -> LEDR[0]=0, ptr frozen 40 cycles; KEY1 press x2 -> ptr +2; KEY0 press -> RUN, first step 4 cycles later.
//  5 In RUN, KEY1 press at ptr 0 -> dir=1, next step ptr=7; KEY0+KEY1 same cycle -> PAUSE only, dir unchanged.
//  6 Assert RST while ptr=5 and KEY0 held -> ptr=0, state RUN, HEX blank during reset; no press registered on release of RST.

Source files
------------

// File: rtl/hex_ui_pkg.sv
// ---------------------------------------------------------------------------
// hex_ui_pkg
// Purpose : Shared constants and types for the seven-segment scroll UI.
//           Holds the active-low segment patterns (bit 0 = segment a,
//           bit 6 = segment g), the controller state enum and a helper
//           that sizes the message pointer.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package hex_ui_pkg;

  // All segments off (active-low), also used for nibbles above 9
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns for the decimal digits
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // Scroll controller modes
  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_t;

  // Bits needed to hold a pointer into an n-digit message (at least one)
  function automatic int ptrWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
// Purpose : Combinational 4-bit to seven-segment decoder, active-low outputs.
//           Nibbles 10..15 render as a blank digit.
// Ports   : i_bcd [3:0]  digit value to display
//           o_seg [6:0]  active-low segments, bit 0 = a ... bit 6 = g
// ---------------------------------------------------------------------------
module bcd_to_seg
  import hex_ui_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Straight lookup; anything that is not a decimal digit stays dark so the
  // message can use 0xF as padding between words.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl
// Purpose : Scrolls an NDIG-digit packed-BCD message across HEX3..HEX0.
//           A prescaler produces base ticks; a step happens every SW+1 ticks
//           while running. KEY0 toggles run/pause, KEY1 reverses direction
//           while running or single-steps while paused.
// Config  : define KEY_DEBOUNCE_EN to insert a DEB_CYC-cycle debouncer after
//           the key synchronizer; otherwise the synchronized level is used.
// Ports   : CLOCK_50        system clock, rising edge
//           RST             synchronous active-high reset
//           KEY  [1:0]      push buttons, active-low, asynchronous
//           SW   [1:0]      speed select (step every SW+1 base ticks)
//           HEX0..HEX3 [6:0] registered active-low segments, HEX0 rightmost
//           LEDR [4:0]      [0] running, [1] direction, [4:2] pointer
// ---------------------------------------------------------------------------
module hex_scroll_ctrl
  import hex_ui_pkg::*;
#(
  parameter int          NDIG     = 8,
  parameter logic [31:0] MSG      = 32'hFFFF6145,
  parameter int          TICK_DIV = 12_500_000,
  parameter int          DEB_CYC  = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic [1:0] KEY,
  input  logic [1:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [4:0] LEDR
);

  localparam int              PW        = ptrWidth(NDIG);
  localparam int              TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   PTR_LAST  = PW'(NDIG - 1);

  logic [1:0]    r_keySync1;
  logic [1:0]    r_keySync2;
  logic [1:0]    r_keyPrev;
  logic [1:0]    w_keyLevel;
  logic [1:0]    w_pressRaw;
  logic          w_pressEn;
  logic          w_press0;
  logic          w_press1;

  state_t        r_state;
  state_t        w_stateNext;
  logic          w_tick;
  logic          w_step;
  logic          w_dirToggle;
  logic          w_resume;

  logic [TW-1:0] r_tickCnt;
  logic [1:0]    r_stepCnt;
  logic [PW-1:0] r_ptr;
  logic          r_dir;

  logic [3:0]    w_digit [4];
  logic [6:0]    w_seg   [4];
  logic [6:0]    r_hex   [4];

  // Two-flop synchronizer. Resetting to 1 makes the keys look released
  // coming out of reset.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      r_keySync1 <= 2'b11;
      r_keySync2 <= 2'b11;
    end else begin
      r_keySync1 <= KEY;
      r_keySync2 <= r_keySync1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int DW    = $clog2(DEB_CYC + 1);
  localparam int BLIND = 3 + DEB_CYC;

  logic [DW-1:0] r_debCnt [2];
  logic [1:0]    r_debLevel;

  // Debouncer: a synchronized key must disagree with the current level for
  // DEB_CYC consecutive cycles before the level follows it.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      r_debLevel  <= 2'b11;
      r_debCnt[0] <= '0;
      r_debCnt[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_keySync2[k] == r_debLevel[k]) begin
          r_debCnt[k] <= '0;
        end else if (r_debCnt[k] == DW'(DEB_CYC - 1)) begin
          r_debLevel[k] <= r_keySync2[k];
          r_debCnt[k]   <= '0;
        end else begin
          r_debCnt[k] <= r_debCnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_keyLevel = r_debLevel;
`else
  localparam int BLIND = 3;

  assign w_keyLevel = r_keySync2;
`endif

  localparam int BW = $clog2(BLIND + 1);

  logic [BW-1:0] r_blindCnt;

  // Edge detect plus a short blind window after reset. The input pipeline
  // refills with live key levels after reset, so a key held through reset
  // would otherwise look like a fresh press; presses are ignored until the
  // pipeline has been flushed.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      r_keyPrev  <= 2'b11;
      r_blindCnt <= '0;
    end else begin
      r_keyPrev <= w_keyLevel;
      if (!w_pressEn) r_blindCnt <= r_blindCnt + 1'b1;
    end
  end

  assign w_pressEn  = (r_blindCnt == BW'(BLIND));
  assign w_pressRaw = r_keyPrev & ~w_keyLevel & {2{w_pressEn}};
  assign w_press0   = w_pressRaw[0];
  assign w_press1   = w_pressRaw[1] & ~w_pressRaw[0];

  assign w_tick = (r_state == RUN) && (r_tickCnt == TICK_LAST);

  // State register for the run/pause controller.
  always_ff @(posedge CLOCK_50) begin
    if (RST) r_state <= RUN;
    else     r_state <= w_stateNext;
  end

  // Next state and step decisions. A pause press wins over both a KEY1
  // press and a coinciding tick, so that tick's step is dropped.
  always_comb begin
    w_stateNext = r_state;
    w_step      = 1'b0;
    w_dirToggle = 1'b0;
    w_resume    = 1'b0;
    case (r_state)
      RUN: begin
        if (w_press0) begin
          w_stateNext = PAUSE;
        end else begin
          if (w_tick && (r_stepCnt >= SW)) w_step = 1'b1;
          if (w_press1) w_dirToggle = 1'b1;
        end
      end
      PAUSE: begin
        if (w_press0) begin
          w_stateNext = RUN;
          w_resume    = 1'b1;
        end else if (w_press1) begin
          w_step = 1'b1;
        end
      end
      default: w_stateNext = RUN;
    endcase
  end

  // Prescaler. Counts only while running and restarts from zero on resume,
  // so the first step after a resume comes a full tick period later.
  always_ff @(posedge CLOCK_50) begin
    if (RST || w_resume) begin
      r_tickCnt <= '0;
      r_stepCnt <= '0;
    end else if (r_state == RUN) begin
      r_tickCnt <= w_tick ? '0 : r_tickCnt + 1'b1;
      if (w_tick) r_stepCnt <= (r_stepCnt >= SW) ? 2'd0 : r_stepCnt + 2'd1;
    end
  end

  // Pointer and direction. A step uses the direction held before any
  // toggle landing in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      r_ptr <= '0;
      r_dir <= 1'b0;
    end else begin
      if (w_dirToggle) r_dir <= ~r_dir;
      if (w_step) begin
        if (r_dir) r_ptr <= (r_ptr == '0) ? PTR_LAST : r_ptr - 1'b1;
        else       r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
      end
    end
  end

  function automatic logic [3:0] digitAt(input logic [PW-1:0] ptr, input int k);
    int idx;
    idx = (int'(ptr) + k) % NDIG;
    return 4'(MSG >> (4 * idx));
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_dec
    assign w_digit[k] = digitAt(r_ptr, k);
    bcd_to_seg u_dec (
      .i_bcd (w_digit[k]),
      .o_seg (w_seg[k])
    );
  end

  // Segment output registers; they trail the pointer by one cycle and are
  // blank while reset is held.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      for (int k = 0; k < 4; k++) r_hex[k] <= SEG_BLANK;
    end else begin
      for (int k = 0; k < 4; k++) r_hex[k] <= w_seg[k];
    end
  end

  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign LEDR = {3'(r_ptr), r_dir, (r_state == RUN)};

endmodule
